serial_adder: RTL

// - Multi-cycle digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock through one carry register.
// - Parametrised successor of the combinational half/full adder cells; trades latency for area.
// - Used in datapath labs needing wide adds with a start/busy/done handshake.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/fa_digit.sv | 23 ++
 rtl/serial_adder.sv | 107 ++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
// Optional subtract mode is enabled with SERIAL_ADDER_SUB_EN (see serial_adder.sv).
package serial_adder_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fa_digit.sv
// Combinational DIGIT-bit ripple-carry adder built from full-adder cells.
module fa_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             ci,
   output logic [DIGIT-1:0] s_d,
   output logic             co
);

   logic [DIGIT:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < DIGIT; i++) begin : g_cell
      assign s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
      assign c[i+1]   = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
   end

   assign co = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit add, DIGIT bits per clock, start/busy/done handshake.
// Defining SERIAL_ADDER_SUB_EN adds a 'sub' port selecting a - b.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = cnt_w(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_e           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_next;
   logic             carry;
   logic [CW-1:0]    count;
   logic [DIGIT-1:0] s_d;
   logic             co;
   logic [WIDTH-1:0] b_in;
   logic             c_in;

   // Subtraction reuses the adder as a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
   assign b_in = sub ? ~b : b;
   assign c_in = sub ? 1'b1 : cin;
`else
   assign b_in = b;
   assign c_in = cin;
`endif

   fa_digit #(.DIGIT(DIGIT)) u_fa (
      .a_d (a_sr[DIGIT-1:0]),
      .b_d (b_sr[DIGIT-1:0]),
      .ci  (carry),
      .s_d (s_d),
      .co  (co)
   );

   // New digit enters at the MSB end so the last digit lands the full result in place.
   if (WIDTH == DIGIT) begin : g_one_digit
      assign res_next = s_d;
   end else begin : g_multi_digit
      assign res_next = {s_d, res_sr[WIDTH-1:DIGIT]};
   end

   assign busy = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         count  <= '0;
         sum    <= '0;
         cout   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b_in;
                  carry <= c_in;
                  count <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> DIGIT;
               b_sr   <= b_sr >> DIGIT;
               res_sr <= res_next;
               carry  <= co;
               count  <= count + 1'b1;
               if (count == LAST) begin
                  sum   <= res_next;
                  cout  <= co;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
